// File: rtl/poly_eval_pipe_if.sv
// Handshake, coefficient-load and status bundle for poly_eval_pipe.
// master = sample source / controller side, slave = evaluator side.
interface poly_eval_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEGREE     = 5
);
  localparam int AW = $clog2(DEGREE + 1);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_x;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_fx;
  logic                         coef_we;
  logic [AW-1:0]                coef_addr;
  logic signed [DATA_WIDTH-1:0] coef_wdata;
  logic                         coef_commit;
  logic                         commit_pending;
  logic                         sat_flag;
  logic                         sat_clr;

  modport master (
    output in_valid, in_x, out_ready, coef_we, coef_addr, coef_wdata,
           coef_commit, sat_clr,
    input  in_ready, out_valid, out_fx, commit_pending, sat_flag
  );

  modport slave (
    input  in_valid, in_x, out_ready, coef_we, coef_addr, coef_wdata,
           coef_commit, sat_clr,
    output in_ready, out_valid, out_fx, commit_pending, sat_flag
  );
endinterface

// File: rtl/poly_eval_pipe.sv
// Pipelined Horner polynomial evaluator: one rounded, saturating MAC per stage,
// stall-on-backpressure, and a double-buffered coefficient bank committed on drain.
module poly_eval_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int DEGREE     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  poly_eval_pipe_if.slave  bus
);

  localparam int PW = 2 * DATA_WIDTH + 1;

  typedef logic signed [DATA_WIDTH-1:0] word_t;
  typedef logic signed [PW-1:0]         wide_t;

  localparam wide_t HALF = wide_t'(1) <<< (FRAC_BITS - 1);
  localparam wide_t MAXV = (wide_t'(1) <<< (DATA_WIDTH - 1)) - wide_t'(1);
  localparam wide_t MINV = -MAXV - wide_t'(1);

  function automatic wide_t round_q(input wide_t p);
    return (p + HALF) >>> FRAC_BITS;
  endfunction

  function automatic logic clamps(input wide_t v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic word_t saturate(input wide_t v);
    if (v > MAXV)      return word_t'(MAXV);
    else if (v < MINV) return word_t'(MINV);
    else               return word_t'(v);
  endfunction

  logic [DEGREE:0]   vld_q;
  word_t             x_q      [DEGREE+1];
  word_t             acc_q    [DEGREE];
  word_t             acc_d    [DEGREE];
  word_t             stage_in [DEGREE];
  logic [DEGREE-1:0] clamp_d;
  word_t             shadow_q [DEGREE+1];
  word_t             active_q [DEGREE+1];
  logic              commit_pending_q, commit_pending_d;
  logic              sat_flag_q, sat_flag_d;
  logic              en, in_fire, drained, copy_en, sat_evt;
  wide_t             sum;

  assign en            = !vld_q[DEGREE] || bus.out_ready;
  assign bus.in_ready  = en && !commit_pending_q && rst_n;
  assign in_fire       = bus.in_valid && bus.in_ready;
  // The last sample may leave on the copy edge: its result is already registered.
  assign drained       = !(|vld_q[DEGREE-1:0]) && (!vld_q[DEGREE] || bus.out_ready);
  assign copy_en       = commit_pending_q && drained;
  assign sat_evt       = en && |(clamp_d & vld_q[DEGREE-1:0]);

  assign bus.out_valid      = vld_q[DEGREE];
  assign bus.out_fx         = acc_q[DEGREE-1];
  assign bus.commit_pending = commit_pending_q;
  assign bus.sat_flag       = sat_flag_q;

  // Stage k (index k-1): acc_k = sat(round(acc_{k-1} * x) + a[DEGREE-k])
  always_comb begin
    sum = '0;
    stage_in[0] = active_q[DEGREE];
    for (int i = 1; i < DEGREE; i++) stage_in[i] = acc_q[i-1];
    for (int i = 0; i < DEGREE; i++) begin
      sum        = round_q(wide_t'(stage_in[i]) * wide_t'(x_q[i]))
                   + wide_t'(active_q[DEGREE-1-i]);
      acc_d[i]   = saturate(sum);
      clamp_d[i] = clamps(sum);
    end
  end

  always_comb begin
    commit_pending_d = commit_pending_q;
    if (copy_en)              commit_pending_d = 1'b0;
    else if (bus.coef_commit) commit_pending_d = 1'b1;
    sat_flag_d = sat_flag_q;
    if (sat_evt)          sat_flag_d = 1'b1;
    else if (bus.sat_clr) sat_flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_pending_q <= 1'b0;
      sat_flag_q       <= 1'b0;
    end else begin
      commit_pending_q <= commit_pending_d;
      sat_flag_q       <= sat_flag_d;
    end
  end

  // s0 captures x; s1..sDEGREE carry acc, x and valid together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i <= DEGREE; i++) x_q[i] <= '0;
      for (int i = 0; i < DEGREE; i++)  acc_q[i] <= '0;
    end else if (en) begin
      vld_q  <= {vld_q[DEGREE-1:0], in_fire};
      x_q[0] <= bus.in_x;
      for (int i = 1; i <= DEGREE; i++) x_q[i] <= x_q[i-1];
      for (int i = 0; i < DEGREE; i++)  acc_q[i] <= acc_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= DEGREE; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (copy_en) active_q <= shadow_q;
      if (bus.coef_we && (int'(bus.coef_addr) <= DEGREE))
        shadow_q[bus.coef_addr] <= bus.coef_wdata;
    end
  end

endmodule
